// File: rtl/lda_avalon_slave.sv
// Avalon-MM register front end for the line-drawing accelerator: CPU-visible
// staging registers, launch-time shadow copies, go/done handshake and stall/poll flow control.
module lda_avalon_slave #(
  parameter int unsigned X_W = 9,
  parameter int unsigned Y_W = 8,
  parameter int unsigned C_W = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2:0]     avs_address,
  input  logic           avs_read,
  input  logic           avs_write,
  input  logic [31:0]    avs_writedata,
  output logic [31:0]    avs_readdata,
  output logic           avs_waitrequest,
  output logic           o_GO,
  input  logic           i_DONE,
  output logic [X_W-1:0] o_x0,
  output logic [Y_W-1:0] o_y0,
  output logic [X_W-1:0] o_x1,
  output logic [Y_W-1:0] o_y1,
  output logic [C_W-1:0] o_colour
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

  localparam logic [2:0] A_MODE   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_GO     = 3'd2;
  localparam logic [2:0] A_START  = 3'd3;
  localparam logic [2:0] A_END    = 3'd4;
  localparam logic [2:0] A_COLOUR = 3'd5;

  state_t         state;
  logic           mode;
  logic           run_mode;
  logic [X_W-1:0] stage_x0, stage_x1;
  logic [Y_W-1:0] stage_y0, stage_y1;
  logic [C_W-1:0] stage_colour;
  logic           go_write;
  logic           go_accept;
  logic           wait_raw;
  logic           write_ok;
  logic           unused_bits;

  assign go_write  = avs_write && (avs_address == A_GO);
  assign go_accept = (state == S_IDLE) && go_write;
  assign write_ok  = avs_write && !avs_waitrequest;
  assign unused_bits = ^avs_writedata[31:X_W+Y_W];

  // Idle stalls on the current MODE; once launched the sampled mode governs.
  always_comb begin
    wait_raw = 1'b0;
    case (state)
      S_IDLE:  wait_raw = !mode && go_write;
      S_BUSY:  wait_raw = !run_mode && (avs_read || avs_write);
      default: wait_raw = 1'b0;
    endcase
  end

  assign avs_waitrequest = reset && wait_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode         <= 1'b0;
      stage_x0     <= '0;
      stage_y0     <= '0;
      stage_x1     <= '0;
      stage_y1     <= '0;
      stage_colour <= '0;
    end else if (write_ok) begin
      case (avs_address)
        A_MODE: if (state == S_IDLE) mode <= avs_writedata[0];
        A_START: begin
          stage_x0 <= avs_writedata[X_W-1:0];
          stage_y0 <= avs_writedata[X_W+Y_W-1:X_W];
        end
        A_END: begin
          stage_x1 <= avs_writedata[X_W-1:0];
          stage_y1 <= avs_writedata[X_W+Y_W-1:X_W];
        end
        A_COLOUR: stage_colour <= avs_writedata[C_W-1:0];
        default: ;
      endcase
    end
  end

  // A done pulse that coincides with go belongs to a previous line and is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      run_mode <= 1'b0;
      o_GO     <= 1'b0;
      o_x0     <= '0;
      o_y0     <= '0;
      o_x1     <= '0;
      o_y1     <= '0;
      o_colour <= '0;
    end else begin
      o_GO <= go_accept;
      case (state)
        S_IDLE: begin
          if (go_accept) begin
            state    <= S_BUSY;
            run_mode <= mode;
            o_x0     <= stage_x0;
            o_y0     <= stage_y0;
            o_x1     <= stage_x1;
            o_y1     <= stage_y1;
            o_colour <= stage_colour;
          end
        end
        S_BUSY: begin
          if (i_DONE && !o_GO) state <= run_mode ? S_IDLE : S_ACK;
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    avs_readdata = '0;
    if (avs_read) begin
      case (avs_address)
        A_MODE:   avs_readdata[0] = mode;
        A_STATUS: avs_readdata[0] = (state != S_IDLE);
        A_START:  avs_readdata[X_W+Y_W-1:0] = {stage_y0, stage_x0};
        A_END:    avs_readdata[X_W+Y_W-1:0] = {stage_y1, stage_x1};
        A_COLOUR: avs_readdata[C_W-1:0] = stage_colour;
        default:  avs_readdata = '0;
      endcase
    end
  end

endmodule
